// File: rtl/y86_fetch_stage.sv
// ----------------------------------------------------------------------------
// y86_fetch_stage
//   Y86-64 fetch stage with an internal byte-wide instruction memory. Owns the
//   PC, decodes icode/ifun/rA/rB/valC/valP from variable-length instructions
//   (1..10 bytes) and registers the result into an F->D pipeline register
//   guarded by a valid/ready handshake, with redirect/flush and status.
//
// Ports
//   clock        in   sole clock, rising edge
//   reset        in   asynchronous, active-high
//   imem_we      in   loader byte write enable
//   imem_waddr   in   loader byte address (ignored if >= MEM_BYTES)
//   imem_wdata   in   loader byte data
//   redirect_vld in   flush and restart fetch at redirect_pc (highest priority)
//   redirect_pc  in   restart address
//   out_ready    in   decode accepts the F->D register this cycle
//   out_valid    out  F->D register holds an instruction
//   icode/ifun   out  byte0[7:4] / byte0[3:0]
//   rA/rB        out  byte1 nibbles, 0xF when there is no register byte
//   valC         out  little-endian 8-byte constant, else 0
//   valP         out  PC + instruction length
//   stat         out  1=AOK 2=HLT 3=ADR 4=INS
//   pred_taken   out  next PC was taken from valC
//
// Configuration
//   FETCH_PREDICT_EN : when defined, jXX/call redirect the next fetch to valC
//                      and raise pred_taken; otherwise next PC is always valP.
// ----------------------------------------------------------------------------
module y86_fetch_stage #(
    parameter int unsigned     MEM_BYTES = 1024,
    parameter int unsigned     PC_W      = 64,
    parameter logic [PC_W-1:0] RESET_PC  = '0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            imem_we,
    input  logic [PC_W-1:0] imem_waddr,
    input  logic [7:0]      imem_wdata,
    input  logic            redirect_vld,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [3:0]      icode,
    output logic [3:0]      ifun,
    output logic [3:0]      rA,
    output logic [3:0]      rB,
    output logic [PC_W-1:0] valC,
    output logic [PC_W-1:0] valP,
    output logic [2:0]      stat,
    output logic            pred_taken
);

    localparam int unsigned   AW      = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
    localparam int unsigned   XW      = PC_W + 1;
    localparam logic [XW-1:0] MEM_LIM = XW'(MEM_BYTES);

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic {
        ST_RUN,
        ST_HALTED
    } state_t;

    // ------------------------------------------------------------------
    // Instruction memory (not cleared by reset; write lands on the edge,
    // so a same-cycle fetch of that byte sees the old value)
    // ------------------------------------------------------------------
    logic [7:0] mem_q [MEM_BYTES];

    always_ff @(posedge clock) begin
        if (imem_we && ({1'b0, imem_waddr} < MEM_LIM)) begin
            mem_q[imem_waddr[AW-1:0]] <= imem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // State / pipeline registers
    // ------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            out_valid_q, out_valid_d;
    logic [3:0]      icode_q, icode_d, ifun_q, ifun_d;
    logic [3:0]      ra_q, ra_d, rb_q, rb_d;
    logic [PC_W-1:0] valc_q, valc_d, valp_q, valp_d;
    logic [2:0]      stat_q, stat_d;
    logic            pred_q, pred_d;

    // ------------------------------------------------------------------
    // Fetch window: addresses are computed one bit wider than the PC so a
    // wrap past 2^PC_W lands above MEM_LIM and is reported as ADR.
    // ------------------------------------------------------------------
    logic [XW-1:0] fa [10];
    logic [7:0]    fb [10];

    always_comb begin
        for (int unsigned k = 0; k < 10; k++) begin
            fa[k] = {1'b0, pc_q} + XW'(k);
            fb[k] = (fa[k] < MEM_LIM) ? mem_q[fa[k][AW-1:0]] : 8'h00;
        end
    end

    // ------------------------------------------------------------------
    // Decode of the instruction at pc_q
    // ------------------------------------------------------------------
    logic [3:0]      f_icode, f_ifun, f_len;
    logic            has_reg, c_at1, c_at2, ifun_ok;
    logic [63:0]     c64;
    logic [XW-1:0]   last_addr;
    logic            adr_err, ins_err, hlt_err, any_err;
    logic [PC_W-1:0] valp_w, next_pc;
    logic [3:0]      dec_icode, dec_ifun, dec_ra, dec_rb;
    logic [PC_W-1:0] dec_valc;
    logic [2:0]      dec_stat;
    logic            dec_pred;

    always_comb begin
        f_icode = fb[0][7:4];
        f_ifun  = fb[0][3:0];
        f_len   = 4'd1;
        has_reg = 1'b0;
        c_at1   = 1'b0;
        c_at2   = 1'b0;
        ifun_ok = (f_ifun == 4'h0);
        case (f_icode)
            4'h2: begin f_len = 4'd2;  has_reg = 1'b1; ifun_ok = (f_ifun <= 4'h6); end
            4'h3,
            4'h4,
            4'h5: begin f_len = 4'd10; has_reg = 1'b1; c_at2 = 1'b1; end
            4'h6: begin f_len = 4'd2;  has_reg = 1'b1; ifun_ok = (f_ifun <= 4'h3); end
            4'h7: begin f_len = 4'd9;  c_at1 = 1'b1;   ifun_ok = (f_ifun <= 4'h6); end
            4'h8: begin f_len = 4'd9;  c_at1 = 1'b1; end
            4'hA,
            4'hB: begin f_len = 4'd2;  has_reg = 1'b1; end
            default: ;
        endcase

        if (c_at2) begin
            c64 = {fb[9], fb[8], fb[7], fb[6], fb[5], fb[4], fb[3], fb[2]};
        end else if (c_at1) begin
            c64 = {fb[8], fb[7], fb[6], fb[5], fb[4], fb[3], fb[2], fb[1]};
        end else begin
            c64 = '0;
        end

        // Contiguous bytes: byte0 and the last byte bound the whole range.
        last_addr = {1'b0, pc_q} + XW'(f_len) - XW'(1);
        adr_err   = (fa[0] >= MEM_LIM) || (last_addr >= MEM_LIM);
        ins_err   = (f_icode > 4'hB) || !ifun_ok;
        hlt_err   = (f_icode == 4'h0);
        any_err   = adr_err || ins_err || hlt_err;
        valp_w    = pc_q + PC_W'(f_len);

        dec_icode = f_icode;
        dec_ifun  = f_ifun;
        dec_ra    = has_reg ? fb[1][7:4] : 4'hF;
        dec_rb    = has_reg ? fb[1][3:0] : 4'hF;
        dec_valc  = PC_W'(c64);
        dec_stat  = STAT_AOK;
        if (adr_err) begin
            dec_icode = 4'h1;
            dec_ifun  = 4'h0;
            dec_ra    = 4'hF;
            dec_rb    = 4'hF;
            dec_valc  = '0;
            dec_stat  = STAT_ADR;
        end else if (ins_err) begin
            dec_stat  = STAT_INS;
        end else if (hlt_err) begin
            dec_stat  = STAT_HLT;
        end

`ifdef FETCH_PREDICT_EN
        dec_pred = (f_icode == 4'h7 || f_icode == 4'h8) && !adr_err && !ins_err;
        next_pc  = dec_pred ? dec_valc : valp_w;
`else
        dec_pred = 1'b0;
        next_pc  = valp_w;
`endif
    end

    // ------------------------------------------------------------------
    // Next-state: redirect > load > drain of a final (halting) transfer
    // ------------------------------------------------------------------
    logic load;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        icode_d     = icode_q;
        ifun_d      = ifun_q;
        ra_d        = ra_q;
        rb_d        = rb_q;
        valc_d      = valc_q;
        valp_d      = valp_q;
        stat_d      = stat_q;
        pred_d      = pred_q;
        load        = (state_q == ST_RUN) && (!out_valid_q || out_ready);

        if (redirect_vld) begin
            out_valid_d = 1'b0;
            pc_d        = redirect_pc;
            state_d     = ST_RUN;
        end else if (load) begin
            out_valid_d = 1'b1;
            icode_d     = dec_icode;
            ifun_d      = dec_ifun;
            ra_d        = dec_ra;
            rb_d        = dec_rb;
            valc_d      = dec_valc;
            valp_d      = valp_w;
            stat_d      = dec_stat;
            pred_d      = dec_pred;
            pc_d        = next_pc;
            state_d     = any_err ? ST_HALTED : ST_RUN;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RUN;
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            icode_q     <= 4'h0;
            ifun_q      <= 4'h0;
            ra_q        <= 4'hF;
            rb_q        <= 4'hF;
            valc_q      <= '0;
            valp_q      <= '0;
            stat_q      <= STAT_AOK;
            pred_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            icode_q     <= icode_d;
            ifun_q      <= ifun_d;
            ra_q        <= ra_d;
            rb_q        <= rb_d;
            valc_q      <= valc_d;
            valp_q      <= valp_d;
            stat_q      <= stat_d;
            pred_q      <= pred_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign icode      = icode_q;
    assign ifun       = ifun_q;
    assign rA         = ra_q;
    assign rB         = rb_q;
    assign valC       = valc_q;
    assign valP       = valp_q;
    assign stat       = stat_q;
    assign pred_taken = pred_q;

endmodule

// File: tb/tb_y86_fetch_stage.sv
module tb_y86_fetch_stage;

    localparam int unsigned MEMB = 1024;
    localparam int unsigned PCW  = 64;

`ifdef FETCH_PREDICT_EN
    localparam logic PRED = 1'b1;
`else
    localparam logic PRED = 1'b0;
`endif

    logic            clock = 1'b0;
    logic            reset;
    logic            imem_we;
    logic [PCW-1:0]  imem_waddr;
    logic [7:0]      imem_wdata;
    logic            redirect_vld;
    logic [PCW-1:0]  redirect_pc;
    logic            out_ready;
    logic            out_valid;
    logic [3:0]      icode, ifun, rA, rB;
    logic [PCW-1:0]  valC, valP;
    logic [2:0]      stat;
    logic            pred_taken;

    y86_fetch_stage #(
        .MEM_BYTES (MEMB),
        .PC_W      (PCW),
        .RESET_PC  (64'h0)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .imem_we      (imem_we),
        .imem_waddr   (imem_waddr),
        .imem_wdata   (imem_wdata),
        .redirect_vld (redirect_vld),
        .redirect_pc  (redirect_pc),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .icode        (icode),
        .ifun         (ifun),
        .rA           (rA),
        .rB           (rB),
        .valC         (valC),
        .valP         (valP),
        .stat         (stat),
        .pred_taken   (pred_taken)
    );

    always #5 clock = ~clock;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wrb(input logic [63:0] a, input logic [7:0] d);
        imem_we    = 1'b1;
        imem_waddr = a;
        imem_wdata = d;
        tick();
        imem_we    = 1'b0;
    endtask

    // raw holds the 10 instruction bytes in memory order, byte0 in the MSBs.
    // lvl: 2 = all fields, 1 = icode/ifun/stat, 0 = icode/stat
    typedef struct {
        logic [63:0] addr;
        logic [79:0] raw;
        int unsigned lvl;
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc, valp;
        logic [2:0]  stat;
        logic        pred;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [63:0] a, input logic [79:0] raw, input int unsigned lvl,
                       input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                       input logic [3:0] rb, input logic [63:0] vc, input logic [63:0] vp,
                       input logic [2:0] st, input logic pr);
        vec_t v;
        v.addr = a; v.raw = raw; v.lvl = lvl;
        v.icode = ic; v.ifun = fn; v.ra = ra; v.rb = rb;
        v.valc = vc; v.valp = vp; v.stat = st; v.pred = pr;
        vq.push_back(v);
    endtask

    initial begin
        logic [7:0]  prog_a [12];
        logic [3:0]  s_ic [8];
        logic [3:0]  s_rb [8];
        logic [63:0] s_vc [8];
        logic [63:0] s_vp [8];
        logic [2:0]  s_st [8];
        int unsigned n;

        reset = 1'b1; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
        redirect_vld = 1'b1; redirect_pc = '0; out_ready = 1'b0;

        add(64'h000, 80'h30F20102030405060708, 2, 4'h3, 4'h0, 4'hF, 4'h2, 64'h0807060504030201, 64'h00A, 3'd1, 1'b0);
        add(64'h100, 80'h20120000000000000000, 2, 4'h2, 4'h0, 4'h1, 4'h2, 64'h0, 64'h102, 3'd1, 1'b0);
        add(64'h110, 80'h26340000000000000000, 2, 4'h2, 4'h6, 4'h3, 4'h4, 64'h0, 64'h112, 3'd1, 1'b0);
        add(64'h120, 80'h27340000000000000000, 2, 4'h2, 4'h7, 4'h3, 4'h4, 64'h0, 64'h122, 3'd4, 1'b0);
        add(64'h130, 80'h60AB0000000000000000, 2, 4'h6, 4'h0, 4'hA, 4'hB, 64'h0, 64'h132, 3'd1, 1'b0);
        add(64'h140, 80'h64AB0000000000000000, 2, 4'h6, 4'h4, 4'hA, 4'hB, 64'h0, 64'h142, 3'd4, 1'b0);
        add(64'h150, 80'h40578877665544332211, 2, 4'h4, 4'h0, 4'h5, 4'h7, 64'h1122334455667788, 64'h15A, 3'd1, 1'b0);
        add(64'h160, 80'h50311000000000000000, 2, 4'h5, 4'h0, 4'h3, 4'h1, 64'h10, 64'h16A, 3'd1, 1'b0);
        add(64'h170, 80'h70400000000000000000, 2, 4'h7, 4'h0, 4'hF, 4'hF, 64'h40, 64'h179, 3'd1, PRED);
        add(64'h180, 80'h80000200000000000000, 2, 4'h8, 4'h0, 4'hF, 4'hF, 64'h200, 64'h189, 3'd1, PRED);
        add(64'h190, 80'h90000000000000000000, 2, 4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'h191, 3'd1, 1'b0);
        add(64'h1A0, 80'hA03F0000000000000000, 2, 4'hA, 4'h0, 4'h3, 4'hF, 64'h0, 64'h1A2, 3'd1, 1'b0);
        add(64'h1B0, 80'hB04F0000000000000000, 2, 4'hB, 4'h0, 4'h4, 4'hF, 64'h0, 64'h1B2, 3'd1, 1'b0);
        add(64'h1C0, 80'h00000000000000000000, 2, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h1C1, 3'd2, 1'b0);
        add(64'h1C8, 80'h01000000000000000000, 1, 4'h0, 4'h1, 4'hF, 4'hF, 64'h0, 64'h0,   3'd4, 1'b0);
        add(64'h1D0, 80'hC0000000000000000000, 1, 4'hC, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0,   3'd4, 1'b0);
        add(64'h3FC, 80'h30F20102030405060708, 0, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0,   3'd3, 1'b0);
        add(64'h3FF, 80'h10000000000000000000, 2, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h400, 3'd1, 1'b0);
        add(64'h3F8, 80'h70400000000000000000, 0, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0,   3'd3, 1'b0);
        add(64'h3F6, 80'h30F20102030405060708, 2, 4'h3, 4'h0, 4'hF, 4'h2, 64'h0807060504030201, 64'h400, 3'd1, 1'b0);
        add(64'hFFFF_FFFF_FFFF_FFFF, 80'h10000000000000000000, 0, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 3'd3, 1'b0);

        // Reset state
        #12;
        chk("rst_valid", 64'(out_valid), 64'h0);
        chk("rst_icode", 64'(icode), 64'h0);
        chk("rst_rA",    64'(rA), 64'hF);
        chk("rst_rB",    64'(rB), 64'hF);
        chk("rst_valC",  valC, 64'h0);
        chk("rst_valP",  valP, 64'h0);
        chk("rst_stat",  64'(stat), 64'h1);
        chk("rst_pred",  64'(pred_taken), 64'h0);
        @(negedge clock);
        reset = 1'b0;
        tick();

        // Table-driven single-instruction decode
        foreach (vq[i]) begin
            vec_t v;
            logic [79:0] r;
            v = vq[i];
            r = v.raw;
            redirect_vld = 1'b1; redirect_pc = v.addr; out_ready = 1'b0;
            for (int unsigned k = 0; k < 10; k++) wrb(v.addr + 64'(k), r[79-8*k -: 8]);
            tick();
            redirect_vld = 1'b0;
            tick();
            chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'h1);
            chk($sformatf("v%0d_icode", i), 64'(icode), 64'(v.icode));
            chk($sformatf("v%0d_stat", i),  64'(stat), 64'(v.stat));
            if (v.lvl >= 1) chk($sformatf("v%0d_ifun", i), 64'(ifun), 64'(v.ifun));
            if (v.lvl >= 2) begin
                chk($sformatf("v%0d_rA", i),   64'(rA), 64'(v.ra));
                chk($sformatf("v%0d_rB", i),   64'(rB), 64'(v.rb));
                chk($sformatf("v%0d_valC", i), valC, v.valc);
                chk($sformatf("v%0d_valP", i), valP, v.valp);
                chk($sformatf("v%0d_pred", i), 64'(pred_taken), 64'(v.pred));
            end
        end

        // irmovq; nop; halt streamed with out_ready high
        prog_a = '{8'h30, 8'hF2, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h10, 8'h00};
        redirect_vld = 1'b1; redirect_pc = 64'h0; out_ready = 1'b1;
        for (int unsigned k = 0; k < 12; k++) wrb(64'(k), prog_a[k]);
        redirect_vld = 1'b0;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (out_valid && n < 8) begin
                s_ic[n] = icode; s_rb[n] = rB; s_vc[n] = valC; s_vp[n] = valP; s_st[n] = stat;
                n++;
            end
        end
        chk("seq1_count", 64'(n), 64'd3);
        if (n >= 3) begin
            chk("seq1_i0_icode", 64'(s_ic[0]), 64'h3);
            chk("seq1_i0_rB",    64'(s_rb[0]), 64'h2);
            chk("seq1_i0_valC",  s_vc[0], 64'h0807060504030201);
            chk("seq1_i0_valP",  s_vp[0], 64'd10);
            chk("seq1_i1_icode", 64'(s_ic[1]), 64'h1);
            chk("seq1_i1_valP",  s_vp[1], 64'd11);
            chk("seq1_i2_stat",  64'(s_st[2]), 64'h2);
            chk("seq1_i2_valP",  s_vp[2], 64'd12);
        end
        chk("seq1_idle", 64'(out_valid), 64'h0);

        // Stall with nops, then release
        redirect_vld = 1'b1; redirect_pc = 64'h0; out_ready = 1'b0;
        for (int unsigned k = 0; k < 8; k++) wrb(64'(k), 8'h10);
        redirect_vld = 1'b0;
        tick();
        chk("stall_valP0", valP, 64'd1);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("stall_hold%0d_valid", c), 64'(out_valid), 64'h1);
            chk($sformatf("stall_hold%0d_valP", c), valP, 64'd1);
        end
        out_ready = 1'b1;
        tick();
        chk("stall_rel_valP2", valP, 64'd2);
        tick();
        chk("stall_rel_valP3", valP, 64'd3);

        // Illegal opcode halts; redirect restarts
        redirect_vld = 1'b1; redirect_pc = 64'h0; out_ready = 1'b1;
        wrb(64'h0, 8'hC0);
        wrb(64'h20, 8'h10);
        redirect_vld = 1'b0;
        tick();
        chk("ins_stat",  64'(stat), 64'h4);
        chk("ins_valid", 64'(out_valid), 64'h1);
        tick();
        chk("ins_drop", 64'(out_valid), 64'h0);
        tick(); tick(); tick();
        chk("ins_halted", 64'(out_valid), 64'h0);
        redirect_vld = 1'b1; redirect_pc = 64'h20;
        tick();
        redirect_vld = 1'b0;
        tick();
        chk("redir_valid", 64'(out_valid), 64'h1);
        chk("redir_icode", 64'(icode), 64'h1);
        chk("redir_valP",  valP, 64'h21);
        chk("redir_stat",  64'(stat), 64'h1);

        // jmp 0x40 at 0: next fetch address depends on prediction
        redirect_vld = 1'b1; redirect_pc = 64'h0; out_ready = 1'b1;
        wrb(64'h0, 8'h70);
        wrb(64'h1, 8'h40);
        for (int unsigned k = 2; k < 9; k++) wrb(64'(k), 8'h00);
        wrb(64'h9, 8'h10);
        wrb(64'h40, 8'h10);
        redirect_vld = 1'b0;
        tick();
        chk("jmp_icode", 64'(icode), 64'h7);
        chk("jmp_pred",  64'(pred_taken), 64'(PRED));
        tick();
        chk("jmp_next_valid", 64'(out_valid), 64'h1);
        chk("jmp_next_valP",  valP, PRED ? 64'h41 : 64'h0A);
        chk("jmp_next_pred",  64'(pred_taken), 64'h0);

        // Asynchronous reset during a stall
        redirect_vld = 1'b1; redirect_pc = 64'h0; out_ready = 1'b0;
        wrb(64'h0, 8'h10);
        redirect_vld = 1'b0;
        tick();
        chk("arst_pre_valid", 64'(out_valid), 64'h1);
        tick();
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", 64'(out_valid), 64'h0);
        chk("arst_icode", 64'(icode), 64'h0);
        chk("arst_rA",    64'(rA), 64'hF);
        chk("arst_stat",  64'(stat), 64'h1);
        tick();
        reset = 1'b0;
        tick();
        chk("arst_fetch_valid", 64'(out_valid), 64'h1);
        chk("arst_fetch_valP",  valP, 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish, got no summary expected summary");
        $fatal(1);
    end

endmodule
